// File: rtl/mest_run_sequencer.sv
// Campaign controller for the MESTPro core: sequences memory/core reset and start
// for NUM_RUNS runs, logs every valid result with its flags, and flags hung runs.
module mest_run_sequencer #(
    parameter int DATA_WIDTH       = 8,
    parameter int LOG_DEPTH        = 16,
    parameter int NUM_RUNS         = 1,
    parameter int MEM_RESET_CYCLES = 1,
    parameter int RESET_HOLD       = 10,
    parameter int START_DELAY      = 10,
    parameter int TIMEOUT_CYCLES   = 65536,
    localparam int AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1,
    localparam int CW = $clog2(LOG_DEPTH + 1),
    localparam int RW = $clog2(NUM_RUNS + 1)
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_go,
    output logic                  o_memory_reset,
    output logic                  o_core_reset_n,
    output logic                  o_start,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_valid_result,
    input  logic                  i_carry,
    input  logic                  i_zero_flag,
    input  logic                  i_all_done,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH+1:0] o_rd_data,
    output logic [CW-1:0]         o_result_count,
    output logic                  o_overflow,
    output logic [RW-1:0]         o_run_index,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout
);

    localparam int MAX_A = (MEM_RESET_CYCLES > RESET_HOLD) ? MEM_RESET_CYCLES : RESET_HOLD;
    localparam int MAX_B = (MAX_A > START_DELAY) ? MAX_A : START_DELAY;
    localparam int MAX_C = (MAX_B > TIMEOUT_CYCLES) ? MAX_B : TIMEOUT_CYCLES;
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] MR_LAST  = TW'(MEM_RESET_CYCLES - 1);
    localparam logic [TW-1:0] CR_LAST  = TW'(RESET_HOLD - 1);
    localparam logic [TW-1:0] PS_LAST  = TW'(START_DELAY - 1);
    localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MEM_RST, S_CORE_RST, S_PRE_START, S_START, S_RUN, S_DONE, S_TIMEOUT
    } state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         cnt_reg;
    logic [RW-1:0]         run_index_reg;
    logic [CW-1:0]         count_reg;
    logic                  overflow_reg;
    logic                  memory_reset_reg, core_reset_n_reg, start_reg;
    logic                  busy_reg, done_reg, timeout_reg;
    logic [DATA_WIDTH+1:0] rd_data_reg;
    logic [DATA_WIDTH+1:0] log_mem [LOG_DEPTH];

    logic go_ok, last_run, log_room, log_we;

    assign go_ok    = i_go && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_TIMEOUT);
    assign last_run = (run_index_reg == RW'(NUM_RUNS - 1));
    assign log_room = (count_reg < CW'(LOG_DEPTH));
    assign log_we   = (state_reg == S_RUN) && i_valid_result && log_room;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_TIMEOUT: if (i_go) state_next = S_MEM_RST;
            S_MEM_RST:   if (cnt_reg == MR_LAST) state_next = S_CORE_RST;
            S_CORE_RST:  if (cnt_reg == CR_LAST) state_next = S_PRE_START;
            S_PRE_START: if (cnt_reg == PS_LAST) state_next = S_START;
            S_START:     state_next = S_RUN;
            S_RUN: begin
                // all-done wins over a coincident timeout
                if (i_all_done)                state_next = last_run ? S_DONE : S_MEM_RST;
                else if (cnt_reg == RUN_LAST)  state_next = S_TIMEOUT;
            end
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_reg        <= S_IDLE;
            cnt_reg          <= '0;
            run_index_reg    <= '0;
            count_reg        <= '0;
            overflow_reg     <= 1'b0;
            memory_reset_reg <= 1'b0;
            core_reset_n_reg <= 1'b0;
            start_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (state_reg inside {S_MEM_RST, S_CORE_RST, S_PRE_START, S_RUN})
                cnt_reg <= cnt_reg + TW'(1);

            if (go_ok) begin
                count_reg     <= '0;
                overflow_reg  <= 1'b0;
                run_index_reg <= '0;
            end else if (state_reg == S_RUN) begin
                if (i_valid_result) begin
                    if (log_room) count_reg    <= count_reg + CW'(1);
                    else          overflow_reg <= 1'b1;
                end
                if (i_all_done && !last_run)
                    run_index_reg <= run_index_reg + RW'(1);
            end

            // Outputs follow the state being entered so they change with it
            memory_reset_reg <= (state_next == S_MEM_RST);
            core_reset_n_reg <= !(state_next inside {S_IDLE, S_MEM_RST, S_CORE_RST});
            start_reg        <= (state_next == S_START);
            busy_reg         <= !(state_next inside {S_IDLE, S_DONE, S_TIMEOUT});
            done_reg         <= (state_next == S_DONE);
            timeout_reg      <= (state_next == S_TIMEOUT);
        end
    end

    // Log RAM is never cleared; the count gate hides stale entries on readback
    always_ff @(posedge clk) begin
        if (log_we)
            log_mem[count_reg[AW-1:0]] <= {i_carry, i_zero_flag, i_result};
        if (!i_reset_n)
            rd_data_reg <= '0;
        else if (CW'(i_rd_addr) < count_reg)
            rd_data_reg <= log_mem[i_rd_addr];
        else
            rd_data_reg <= '0;
    end

    assign o_memory_reset = memory_reset_reg;
    assign o_core_reset_n = core_reset_n_reg;
    assign o_start        = start_reg;
    assign o_busy         = busy_reg;
    assign o_done         = done_reg;
    assign o_timeout      = timeout_reg;
    assign o_overflow     = overflow_reg;
    assign o_result_count = count_reg;
    assign o_run_index    = run_index_reg;
    assign o_rd_data      = rd_data_reg;

endmodule

// File: tb/tb_mest_run_sequencer.sv
// Scoreboard bench: dut_a (LOG_DEPTH=4, TIMEOUT_CYCLES=8) for single-run behaviour,
// dut_b (NUM_RUNS=3, short reset phases) for multi-run sequencing.
module tb_mest_run_sequencer;

    typedef struct packed {
        logic [3:0] mr_pulses;
        logic [3:0] st_pulses;
        logic [7:0] count;
        logic [7:0] run_index;
        logic       overflow;
        logic       done;
        logic       timeout;
        logic       busy;
        logic       start;
        logic       core_reset_n;
        logic       memory_reset;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_go, a_valid, a_carry, a_zero, a_all_done;
    logic [7:0] a_result;
    logic [1:0] a_rd_addr;
    logic       a_mem_reset, a_core_reset_n, a_start, a_overflow, a_busy, a_done, a_timeout;
    logic [9:0] a_rd_data;
    logic [2:0] a_count;
    logic [0:0] a_run_index;

    logic       b_go, b_valid, b_carry, b_zero, b_all_done;
    logic [7:0] b_result;
    logic [3:0] b_rd_addr;
    logic       b_mem_reset, b_core_reset_n, b_start, b_overflow, b_busy, b_done, b_timeout;
    logic [9:0] b_rd_data;
    logic [4:0] b_count;
    logic [1:0] b_run_index;

    mest_run_sequencer #(.LOG_DEPTH(4), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .i_reset_n(rst_n), .i_go(a_go),
        .o_memory_reset(a_mem_reset), .o_core_reset_n(a_core_reset_n), .o_start(a_start),
        .i_result(a_result), .i_valid_result(a_valid), .i_carry(a_carry),
        .i_zero_flag(a_zero), .i_all_done(a_all_done), .i_rd_addr(a_rd_addr),
        .o_rd_data(a_rd_data), .o_result_count(a_count), .o_overflow(a_overflow),
        .o_run_index(a_run_index), .o_busy(a_busy), .o_done(a_done), .o_timeout(a_timeout)
    );

    mest_run_sequencer #(.NUM_RUNS(3), .MEM_RESET_CYCLES(2), .RESET_HOLD(3), .START_DELAY(2)) dut_b (
        .clk(clk), .i_reset_n(rst_n), .i_go(b_go),
        .o_memory_reset(b_mem_reset), .o_core_reset_n(b_core_reset_n), .o_start(b_start),
        .i_result(b_result), .i_valid_result(b_valid), .i_carry(b_carry),
        .i_zero_flag(b_zero), .i_all_done(b_all_done), .i_rd_addr(b_rd_addr),
        .o_rd_data(b_rd_data), .o_result_count(b_count), .o_overflow(b_overflow),
        .o_run_index(b_run_index), .o_busy(b_busy), .o_done(b_done), .o_timeout(b_timeout)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         a_start_q[$];
    int         b_start_q[$];
    int         tmo_q[$];
    logic [9:0] rd_q[$];
    snap_t      snap_q[$];

    logic rd_req = 1'b0, rd_req_d = 1'b0;
    logic snap_req = 1'b0, snap_req_d = 1'b0, snap_sel = 1'b0, snap_sel_d = 1'b0;
    always @(posedge clk) begin
        rd_req_d   <= rd_req;
        snap_req_d <= snap_req;
        snap_sel_d <= snap_sel;
    end

    logic       a_tmo_prev = 1'b0, b_mr_prev = 1'b0;
    logic [3:0] b_mr_cnt = 4'd0, b_st_cnt = 4'd0;
    snap_t      act_a, act_b;
    assign act_a = {4'd0, 4'd0, 8'(a_count), 8'(a_run_index), a_overflow, a_done, a_timeout,
                    a_busy, a_start, a_core_reset_n, a_mem_reset};
    assign act_b = {b_mr_cnt, b_st_cnt, 8'(b_count), 8'(b_run_index), b_overflow, b_done, b_timeout,
                    b_busy, b_start, b_core_reset_n, b_mem_reset};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an observable event
    always @(negedge clk) begin
        if (a_start === 1'b1) begin
            if (a_start_q.size() == 0) chk("a_start_unexpected", 1, 0);
            else                       chk("a_start_cycle", cyc, a_start_q.pop_front());
        end
        if (b_start === 1'b1) begin
            b_st_cnt = b_st_cnt + 4'd1;
            if (b_start_q.size() == 0) chk("b_start_unexpected", 1, 0);
            else                       chk("b_start_cycle", cyc, b_start_q.pop_front());
        end
        if (b_mem_reset === 1'b1 && !b_mr_prev) b_mr_cnt = b_mr_cnt + 4'd1;
        b_mr_prev = (b_mem_reset === 1'b1);
        if (a_timeout === 1'b1 && !a_tmo_prev) begin
            if (tmo_q.size() == 0) chk("a_timeout_unexpected", 1, 0);
            else                   chk("a_timeout_cycle", cyc, tmo_q.pop_front());
        end
        a_tmo_prev = (a_timeout === 1'b1);
        if (rd_req_d) begin
            if (rd_q.size() == 0) chk("a_rd_unexpected", 1, 0);
            else                  chk("a_rd_data", a_rd_data, rd_q.pop_front());
        end
        if (snap_req_d) begin
            if (snap_q.size() == 0) chk("snap_unexpected", 1, 0);
            else if (snap_sel_d)    chk("b_status", act_b, snap_q.pop_front());
            else                    chk("a_status", act_a, snap_q.pop_front());
        end
    end

    function automatic snap_t mk(input int mr, input int st, input int cnt, input int ri,
                                 input bit ov, input bit dn, input bit tm, input bit bz, input bit crn);
        snap_t s;
        s.mr_pulses    = 4'(mr);
        s.st_pulses    = 4'(st);
        s.count        = 8'(cnt);
        s.run_index    = 8'(ri);
        s.overflow     = ov;
        s.done         = dn;
        s.timeout      = tm;
        s.busy         = bz;
        s.start        = 1'b0;
        s.core_reset_n = crn;
        s.memory_reset = 1'b0;
        return s;
    endfunction

    task automatic snap(input bit sel, input snap_t e);
        @(negedge clk);
        snap_q.push_back(e);
        snap_sel = sel;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, input logic [9:0] e);
        @(negedge clk);
        a_rd_addr = addr;
        rd_q.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic go_a();
        @(negedge clk);
        a_go = 1'b1;
        a_start_q.push_back(cyc + 22);
        @(negedge clk);
        a_go = 1'b0;
    endtask

    task automatic wait_start(input bit sel);
        bit seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if ((sel ? b_start : a_start) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("start_wait_bound", 0, 1);
    endtask

    task automatic run_cycle(input logic v, input logic [7:0] r, input logic c, input logic z, input logic d);
        @(negedge clk);
        a_valid = v; a_result = r; a_carry = c; a_zero = z; a_all_done = d;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        rst_n = 1'b0;
        a_go = 0; a_valid = 0; a_carry = 0; a_zero = 0; a_all_done = 0; a_result = 0; a_rd_addr = 0;
        b_go = 0; b_valid = 0; b_carry = 0; b_zero = 0; b_all_done = 0; b_result = 0; b_rd_addr = 0;
        repeat (3) @(negedge clk);
        snap(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        snap(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Default timing, ignored go pulses, valid outside RUN, three logged results
        @(negedge clk);
        a_go = 1'b1;
        c = cyc;
        a_start_q.push_back(c + 22);
        @(negedge clk); a_go = 1'b0;
        repeat (3) @(negedge clk); a_go = 1'b1;
        @(negedge clk); a_go = 1'b0;
        repeat (10) @(negedge clk); a_valid = 1'b1; a_result = 8'hAA;
        @(negedge clk); a_valid = 1'b0;
        wait_start(0);
        run_cycle(1, 8'd5, 0, 0, 0);
        run_cycle(1, 8'd0, 1, 1, 0);
        a_go = 1'b1;
        run_cycle(1, 8'd255, 0, 0, 0);
        a_go = 1'b0;
        run_cycle(0, 8'd0, 0, 0, 1);
        run_cycle(0, 8'd0, 0, 0, 0);
        snap(0, mk(0, 0, 3, 0, 0, 1, 0, 0, 1));
        rd(2'd0, 10'h005);
        rd(2'd1, 10'h300);
        rd(2'd2, 10'h0FF);
        rd(2'd3, 10'h000);

        // Timeout after 8 RUN cycles; valid on the last RUN cycle is still logged
        go_a();
        wait_start(0);
        tmo_q.push_back(cyc + 9);
        repeat (7) @(negedge clk);
        run_cycle(1, 8'h3C, 1, 0, 0);
        run_cycle(0, 8'd0, 0, 0, 0);
        snap(0, mk(0, 0, 1, 0, 0, 0, 1, 0, 1));
        rd(2'd0, 10'h23C);

        // Log overflow: six results into four entries
        go_a();
        wait_start(0);
        for (int i = 1; i <= 6; i++)
            run_cycle(1, 8'(8'h11 * i), i[0], (i == 2), 0);
        run_cycle(0, 8'd0, 0, 0, 1);
        run_cycle(0, 8'd0, 0, 0, 0);
        snap(0, mk(0, 0, 4, 0, 1, 1, 0, 0, 1));
        rd(2'd0, 10'h211);
        rd(2'd1, 10'h122);
        rd(2'd2, 10'h233);
        rd(2'd3, 10'h044);

        // Reset in the middle of RUN with two results logged, then restart
        go_a();
        wait_start(0);
        run_cycle(1, 8'h77, 0, 0, 0);
        run_cycle(1, 8'h88, 1, 1, 0);
        run_cycle(0, 8'd0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        snap(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rd(2'd0, 10'h000);
        go_a();
        wait_start(0);
        run_cycle(0, 8'd0, 0, 0, 1);
        run_cycle(0, 8'd0, 0, 0, 0);
        snap(0, mk(0, 0, 0, 0, 0, 1, 0, 0, 1));

        // Three-run campaign: start 8 cycles after go and after each intermediate all_done
        @(negedge clk);
        b_go = 1'b1;
        b_start_q.push_back(cyc + 8);
        @(negedge clk); b_go = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_start(1);
            @(negedge clk); b_valid = 1'b1; b_result = 8'(8'h40 + r);
            @(negedge clk); b_valid = 1'b0; b_all_done = 1'b1;
            if (r < 2) b_start_q.push_back(cyc + 8);
            @(negedge clk); b_all_done = 1'b0;
        end
        snap(1, mk(3, 3, 3, 2, 0, 1, 0, 0, 1));

        repeat (4) @(negedge clk);
        chk("a_start_q_drained", a_start_q.size(), 0);
        chk("b_start_q_drained", b_start_q.size(), 0);
        chk("tmo_q_drained", tmo_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("snap_q_drained", snap_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mest_run_sequencer.md
# mest_run_sequencer

Synthesisable run controller and result logger for the MESTPro core. It sequences memory reset, core reset and the start pulse for `NUM_RUNS` back-to-back program runs. It captures every valid result with its carry and zero flags into an on-chip log for readback, and flags runs that never assert all-done. It sits between a host/bench controller and the core, and replaces open-loop timed stimulus with a handshake-driven, parametrised campaign.

## Interface
Parameters:
- `DATA_WIDTH`, 8, result width
- `LOG_DEPTH`, 16, number of result log entries (≥1)
- `NUM_RUNS`, 1, runs per campaign (≥1)
- `MEM_RESET_CYCLES`, 1, cycles `o_memory_reset` is held high per run (≥1)
- `RESET_HOLD`, 10, cycles core reset is held after memory reset (≥1)
- `START_DELAY`, 10, cycles between core reset release and start pulse (≥1)
- `TIMEOUT_CYCLES`, 65536, maximum RUN cycles before timeout (≥2)

Ports (AW = $clog2(LOG_DEPTH), CW = $clog2(LOG_DEPTH+1), RW = $clog2(NUM_RUNS+1)):
- `clk` in 1: single clock, rising edge
- `i_reset_n` in 1: synchronous, active-low reset
- `i_go` in 1: campaign start pulse
- `o_memory_reset` out 1: program/data memory reset to core
- `o_core_reset_n` out 1: active-low reset to core
- `o_start` out 1: one-cycle start pulse to core
- `i_result` in DATA_WIDTH: core result
- `i_valid_result` in 1: result qualifier
- `i_carry` in 1: carry flag accompanying result
- `i_zero_flag` in 1: zero flag accompanying result
- `i_all_done` in 1: core program-complete
- `i_rd_addr` in AW: log read address
- `o_rd_data` out DATA_WIDTH+2: `{carry, zero, result}` read data
- `o_result_count` out CW: entries written
- `o_overflow` out 1: sticky, result dropped because log full
- `o_run_index` out RW: current or last run number
- `o_busy`, `o_done`, `o_timeout` out 1 each: status

## Operation
- FSM states: IDLE, MEM_RST, CORE_RST, PRE_START, START, RUN, DONE, TIMEOUT. All outputs are registered and decoded from the state (Moore).
- `i_go` is accepted only in IDLE, DONE or TIMEOUT.
  - On acceptance, count, overflow, run index and the done/timeout flags are cleared.
  - The next state is MEM_RST.
  - `i_go` in any other state is ignored.
- MEM_RST: `o_memory_reset`=1 and `o_core_reset_n`=0 for MEM_RESET_CYCLES cycles, then CORE_RST.
- CORE_RST: `o_core_reset_n`=0 for RESET_HOLD cycles, then PRE_START.
- PRE_START: `o_core_reset_n`=1 for START_DELAY cycles, then START.
- START: `o_start`=1 for exactly one cycle, then RUN.
- RUN: the cycle counter starts at 0 and increments each cycle.
  - `i_all_done` with `o_run_index`==NUM_RUNS-1 → DONE.
  - `i_all_done` otherwise → increment run index, then MEM_RST (core re-reset between runs).
  - Counter reaching TIMEOUT_CYCLES-1 without `i_all_done` → TIMEOUT.
- DONE: `o_done`=1. TIMEOUT: `o_timeout`=1. Both hold `o_core_reset_n`=1 and wait for `i_go`.
- `o_busy`=1 in every state except IDLE, DONE and TIMEOUT.
- Logging:
  - `i_valid_result` is sampled only in RUN; it is ignored elsewhere.
  - If count<LOG_DEPTH, `{i_carry,i_zero_flag,i_result}` is written at address count and count increments.
  - Otherwise the result is dropped and `o_overflow` is set.
  - The log accumulates across all runs of a campaign.
- Same cycle valid + all_done: the result is logged, then the transition occurs.
- Same cycle valid + timeout: the result is logged, then TIMEOUT.
- Readback: `o_rd_data` is registered. Its value equals entry `i_rd_addr` if `i_rd_addr`<count, else 0. Readback works in any state.

## Timing
- Reset values: state IDLE, `o_memory_reset`=0, `o_core_reset_n`=0, `o_start`=0, `o_busy`=0, `o_done`=0, `o_timeout`=0, `o_overflow`=0, `o_result_count`=0, `o_run_index`=0, `o_rd_data`=0.
- Reset mid-campaign: IDLE on the next edge, all outputs as above. Log RAM contents are not cleared, but count=0, so reads return 0.
- With `i_go` sampled at edge 0:
  - `o_memory_reset` is high on cycles 1..M.
  - Core reset is low through cycle M+R.
  - `o_core_reset_n` is high from cycle M+R+1.
  - `o_start` is high on cycle M+R+S+1.
  - RUN begins at cycle M+R+S+2.
  - Defaults: start on cycle 22.
- Result logged at edge k: `o_result_count` updates at k+1, and the entry is readable with `o_rd_data` valid one edge after the address is applied.
- `i_all_done` sampled at edge k: `o_done` is high from k+1, or `o_memory_reset` is high from k+1 for the next run.
- Timeout: `o_timeout` is high exactly TIMEOUT_CYCLES cycles after RUN entry.

## Test plan
- Defaults, `i_go` once, core emits 3 results (5/c0/z0, 0/c1/z1, 255/c0/z0) then all_done → `o_start` on cycle 22 only; count=3; reads give 0x005, 0x300, 0x0FF; `o_done`=1; addr 3 reads 0.
- NUM_RUNS=3, one result per run → `o_memory_reset` pulses 3 times, 3 start pulses, count=3, final `o_run_index`=2, `o_done`=1.
- LOG_DEPTH=4, 6 results → count=4, `o_overflow`=1, entries 0..3 hold the first four results.
- TIMEOUT_CYCLES=8, all_done never asserted → `o_timeout`=1 at RUN+8, `o_busy`=0; valid on the final RUN cycle is still logged.
- `i_reset_n` low for one cycle during RUN with count=2 → all outputs at reset values next cycle, count=0; new `i_go` restarts at cycle 22.
- `i_go` pulsed during CORE_RST and RUN → ignored, timing unchanged; `i_valid_result` in PRE_START → not logged.
